// File: rtl/regfile_wr_stage.sv
// Write-port staging for the register file: valid/ready with one-entry skid, one-hot write
// enables, written-scoreboard and saturating write counter. Optional: REGFILE_ZERO_PROTECT_EN.
module regfile_wr_stage #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**SEL_W-1:0]  out_we,
  output logic [SEL_W-1:0]     out_sel,
  output logic [DW-1:0]        out_data,
  output logic [2**SEL_W-1:0]  written,
  input  logic                 clr_written,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int unsigned N = 2**SEL_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d, skid_sel_q, skid_sel_d;
  logic [DW-1:0]      out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [N-1:0]       written_q, written_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, load, xfer;

  always_comb begin
    accept = in_valid && in_ready_q;
`ifdef REGFILE_ZERO_PROTECT_EN
    // Writes to register 0 complete the handshake but are silently dropped.
    load = accept && (in_sel != '0);
`else
    load = accept;
`endif
    xfer = (state_q != StEmpty) && out_ready;

    state_d     = state_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    skid_sel_d  = skid_sel_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      StEmpty: begin
        if (load) begin
          state_d    = StOne;
          out_sel_d  = in_sel;
          out_data_d = in_data;
        end
      end
      StOne: begin
        if (load && xfer) begin
          out_sel_d  = in_sel;
          out_data_d = in_data;
        end else if (load) begin
          state_d     = StFull;
          skid_sel_d  = in_sel;
          skid_data_d = in_data;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so no accept can race the skid drain.
        if (xfer) begin
          state_d    = StOne;
          out_sel_d  = skid_sel_q;
          out_data_d = skid_data_q;
        end
      end
      default: state_d = StEmpty;
    endcase

    in_ready_d = (state_d != StFull);

    // Clear first so a coincident transfer still leaves its bit set.
    written_d = clr_written ? '0 : written_q;
    if (xfer) written_d[out_sel_q] = 1'b1;

    cnt_d = cnt_q;
    if (xfer && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      skid_sel_q  <= '0;
      skid_data_q <= '0;
      written_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_data_q <= skid_data_d;
      written_q   <= written_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;
  assign out_we    = out_valid ? ({{(N-1){1'b0}}, 1'b1} << out_sel_q) : '0;
  assign written   = written_q;
  assign wr_count  = cnt_q;

endmodule

// File: doc/regfile_wr_stage.md
# regfile_wr_stage

Parametrised write-port staging block for the register file. It generalises the fixed 2/4/8-way write-enable demultiplexers to any power-of-two register count and arbitrary data width. A valid/ready handshake with a one-entry skid buffer lets the writeback path stall, and a per-register "written" scoreboard plus a write counter track activity. It sits between the writeback stage and the register-file storage array, and drives one-hot write enables into the array.

## Interface
Parameters:
- SEL_W, 5, register-select width; register count N = 2**SEL_W (local, not overridable)
- DW, 32, write-data width
- CNT_W, 16, width of the write counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream write request valid
- in_ready  output  1  block can accept a request (registered)
- in_sel  input  SEL_W  target register index
- in_data  input  DW  write data
- out_valid  output  1  staged write pending toward the array
- out_ready  input  1  array accepts the staged write this cycle
- out_we  output  N  one-hot write enable; equals 1<<out_sel when out_valid, else all zero
- out_sel  output  SEL_W  staged register index
- out_data  output  DW  staged write data
- written  output  N  scoreboard; bit i set once register i has been written
- clr_written  input  1  clear the scoreboard
- wr_count  output  CNT_W  number of completed output transfers, saturating

## Operation
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- Output register (OUT) and skid register (SKID), each holding valid/sel/data.
- Accept with OUT empty, or with OUT transferring the same cycle and SKID empty: request loads OUT.
- Accept with OUT full and not transferring: request loads SKID.
- Transfer with SKID valid: SKID moves to OUT and SKID empties. No accept is possible that cycle because in_ready=0.
- in_ready next = !(SKID valid after this edge). It is never asserted while SKID holds data.
- Order is strictly preserved; no request is lost or duplicated.
- out_we is decoded from the registered out_sel/out_valid only, so no path exists from in_* to out_we.
- Scoreboard: on transfer, written[out_sel] is set. clr_written clears all bits. If clear and transfer occur together, clear is applied first and the transferred bit ends up set.
- wr_count increments by 1 per transfer and saturates at 2**CNT_W-1. clr_written does not affect it.

States (derived from the OUT/SKID valid bits):
- EMPTY: OUT=0, SKID=0.
- ONE: OUT=1, SKID=0.
- FULL: OUT=1, SKID=1.
- Transitions: EMPTY->ONE on accept. ONE->EMPTY on transfer without accept. ONE->FULL on accept without transfer. FULL->ONE on transfer. ONE->ONE on simultaneous accept and transfer.

## Timing
- Reset values: in_ready=1, out_valid=0, out_we=0, out_sel=0, out_data=0, written=0, wr_count=0. SKID is emptied.
- Reset mid-operation discards OUT and SKID contents with no write enable asserted.
- Latency: accept at edge k gives out_valid=1 and out_we valid in cycle k+1 when the block was EMPTY.
- Throughput: one write per cycle with out_ready held high.
- in_ready deasserts the cycle after SKID fills and reasserts the cycle after SKID drains.
- out_sel/out_data are stable while out_valid && !out_ready.

## Configuration
- REGFILE_ZERO_PROTECT_EN defined: an accepted request with in_sel==0 is consumed and dropped. The accept handshake is unchanged. The request never enters OUT or SKID, never asserts out_we[0], never sets written[0], and is not counted.
- REGFILE_ZERO_PROTECT_EN undefined: index 0 is treated like every other register.

## Test plan
- Reset, then a single request sel=5, data=0xDEADBEEF, out_ready=1 -> next cycle out_we=0x00000020, out_data=0xDEADBEEF; written[5]=1; wr_count=1.
- out_ready=0, three back-to-back requests to sel 1,2,3 -> OUT holds 1, SKID holds 2, in_ready=0 from the third cycle and request 3 is held. Releasing out_ready -> writes 1,2,3 in order; wr_count=3.
- Continuous stream sel=0..31 with out_ready=1 -> one out_we pulse per cycle, in_ready constantly 1, written=0xFFFFFFFF (or 0xFFFFFFFE with the macro).
- clr_written asserted in the same cycle as a transfer to sel=7 -> written=0x00000080 afterwards.
- rst asserted while FULL -> next cycle out_valid=0, out_we=0, in_ready=1, written=0, wr_count=0.
- With REGFILE_ZERO_PROTECT_EN defined, request sel=0 accepted -> out_valid stays 0, written[0]=0, wr_count unchanged.
